mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single 256-bit DDR/memory line port between the instruction cache (read-only line fills) and the data cache (line fills, write-backs and flush write-backs).
- Sits between both cache controllers and the memory model/controller.
- Issues one transaction at a time, latches the winning command, and returns mem_rd/mem_ready only to the owner.
- Arbitration is D-cache priority with a bounded-starvation guarantee for the I-cache, plus a watchdog on memory latency.

Parameters:
- ADDR_WIDTH, 28, line address width (byte-offset bits already zero from the caches).
- LINE_WIDTH, 256, memory line width in bits.
- STARVE_LIMIT, 4, maximum consecutive D grants while the I-cache is waiting.
- TIMEOUT, 1024, number of BUSY cycles without mem_ready before timeout_err sets.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- i_addr  in  ADDR_WIDTH  I-cache fill address.
- i_valid  in  1  I-cache request; held high until i_ready.
- i_rd  out  LINE_WIDTH  fill data to the I-cache; 0 unless completing an I transaction.
- i_ready  out  1  one-cycle completion strobe to the I-cache.
- d_addr  in  ADDR_WIDTH  D-cache address.
- d_wr  in  LINE_WIDTH  D-cache write-back data.
- d_rw  in  1  1 = write, 0 = read.
- d_valid  in  1  D-cache request; held high until d_ready.
- d_rd  out  LINE_WIDTH  fill data to the D-cache; 0 unless completing a D read.
- d_ready  out  1  one-cycle completion strobe to the D-cache.
- mem_addr  out  ADDR_WIDTH  latched command address.
- mem_wr  out  LINE_WIDTH  latched write data.
- mem_rw  out  1  latched direction.
- mem_valid  out  1  high throughout BUSY.
- mem_rd  in  LINE_WIDTH  memory read data.
- mem_ready  in  1  memory completion, valid only during BUSY.
- owner  out  1  0 = I-cache, 1 = D-cache; valid only while busy.
- busy  out  1  high when the FSM is in BUSY.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset is synchronous, active-low. When rst_n=0 at a clk edge:
  - state goes to IDLE;
  - all outputs go to 0 (mem_addr, mem_wr, mem_rw, mem_valid, i_ready, d_ready, i_rd, d_rd, owner, busy, timeout_err);
  - d_streak and wdog clear.
- Reset mid-BUSY abandons the transaction with no ready strobe to either cache.
- FSM has two states: IDLE and BUSY.
- IDLE:
  - If any request is valid, the grant is decided this cycle.
  - The grantee's addr/wr/rw are latched (I grant: mem_rw=0, mem_wr=0).
  - owner is set and the next state is BUSY.
  - With no request, stay in IDLE.
  - mem_ready is ignored in IDLE.
- Grant rule:
  - Only one request valid: grant it.
  - Both valid: grant D unless d_streak==STARVE_LIMIT, in which case grant I.
- d_streak (width of clog2(STARVE_LIMIT+1)):
  - On a D grant with i_valid=1: increment, saturating at STARVE_LIMIT.
  - On an I grant, or a D grant with i_valid=0: clear.
- BUSY:
  - mem_valid=1 and the mem_* outputs are stable from latched registers; live requester inputs are ignored.
  - On mem_ready=1: combinationally drive the owner's *_ready=1 and, for reads, *_rd=mem_rd in the same cycle; next state is IDLE.
  - The non-owner sees ready=0 and rd=0.
- Latency:
  - Request seen in IDLE at cycle t gives mem_valid at t+1.
  - Earliest completion is at t+1 (mem_ready in the first BUSY cycle).
  - The arbiter is back in IDLE at t+2, guaranteeing at least one mem_valid-low cycle between transactions.
- Back-to-back from one requester: the D-cache moving WRITE_BACK→ALLOCATE with d_valid held high is a new request and is re-arbitrated in the IDLE cycle.
- Requester dropping valid during BUSY:
  - No abort; the transaction completes and the ready strobe is still issued.
- Watchdog:
  - wdog counter clears on entering BUSY and increments each BUSY cycle without mem_ready.
  - When it reaches TIMEOUT-1, timeout_err sets and stays set until reset.
  - The FSM keeps waiting after timeout_err sets.
  - The counter saturates rather than wrapping.
- Simultaneous mem_ready and a new request in the same cycle: the completion is served; the new request is arbitrated next cycle in IDLE.

Decomposition:
- Shared package mem_if_pkg holds:
  - state encodings ST_IDLE=1'b0, ST_BUSY=1'b1;
  - OWNER_I=1'b0, OWNER_D=1'b1;
  - line/address width constants shared with the cache controllers.
- One natural sub-module, arb_grant_logic: the combinational grant decision plus the d_streak register.
- The FSM, command latch and watchdog stay in the top module.

Test Plan:
1. Only i_valid=1, i_addr=0x0001230, mem_ready 3 cycles after mem_valid rises → mem_addr=0x0001230, mem_rw=0; i_ready pulses 1 cycle with i_rd=mem_rd; d_ready stays 0.
2. Both requests valid at once, d_rw=1, d_addr=0x0004560, d_wr=0xAA..AA → D granted first (owner=1, mem_rw=1, mem_wr=0xAA..AA); I granted after the one IDLE gap.
3. d_valid held high continuously while i_valid=1, STARVE_LIMIT=4 → grant order D,D,D,D,I,D...; no more than 4 consecutive D grants.
4. mem_ready=1 in the first BUSY cycle → d_ready at t+1, mem_valid=0 at t+2; mem_ready pulsed during IDLE produces no ready strobe.
5. mem_ready withheld for 1024 BUSY cycles → timeout_err=1 at the 1024th cycle and sticky; a late mem_ready still completes to the owner.
6. rst_n=0 asserted mid-BUSY → at the next edge all outputs are 0, state is IDLE, and no ready strobe is issued; the next request is granted normally.

Source files
------------

// File: rtl/mem_if_pkg.sv
// mem_if_pkg
// Shared definitions for the memory line port and the cache controllers that
// use it: line/address widths, arbiter FSM state encodings, owner encodings
// and a small helper that sizes saturating counters.
package mem_if_pkg;

    localparam int MEM_ADDR_WIDTH = 28;
    localparam int MEM_LINE_WIDTH = 256;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // Number of bits needed to hold the values 0..maxVal.
    function automatic int bitsFor(input int maxVal);
        return (maxVal <= 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/arb_grant_logic.sv
// arb_grant_logic
// Combinational grant decision between the I-cache and D-cache requests,
// plus the d_streak register that bounds how long the I-cache can starve.
// Ports:
//   clk_i      system clock
//   rst_ni     synchronous active-low reset
//   iValid_i   I-cache request
//   dValid_i   D-cache request
//   grantEn_i  a grant is being taken this cycle (arbiter idle, some request)
//   grantD_o   1 = D-cache wins, 0 = I-cache wins
module arb_grant_logic
    import mem_if_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic iValid_i,
    input  logic dValid_i,
    input  logic grantEn_i,
    output logic grantD_o
);

    localparam int STREAK_W = bitsFor(STARVE_LIMIT);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    logic [STREAK_W-1:0] dStreak_q;

    // The D-cache wins whenever it asks, except when the I-cache is also
    // waiting and has already been passed over STARVE_LIMIT times in a row.
    always_comb begin
        grantD_o = dValid_i && !(iValid_i && (dStreak_q == STREAK_MAX));
    end

    // The streak counts only D grants taken while the I-cache was waiting;
    // any I grant, or a D grant with no competition, starts it over.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dStreak_q <= '0;
        end else if (grantEn_i) begin
            if (grantD_o && iValid_i) begin
                if (dStreak_q != STREAK_MAX) begin
                    dStreak_q <= dStreak_q + STREAK_W'(1);
                end
            end else begin
                dStreak_q <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single memory line port between the I-cache (line fills) and
// the D-cache (fills and write-backs). One transaction at a time: the winning
// command is latched on the IDLE->BUSY step, held on mem_* for the whole BUSY
// period, and the completion (ready strobe plus read data) is routed back
// only to the owner. A sticky watchdog flags excessive memory latency.
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   i_addr, i_valid / i_rd, i_ready   I-cache request / completion
//   d_addr, d_wr, d_rw, d_valid       D-cache request
//   d_rd, d_ready                     D-cache completion
//   mem_addr, mem_wr, mem_rw,
//   mem_valid / mem_rd, mem_ready     memory command / response
//   owner, busy, timeout_err          status
module mem_port_arbiter
    import mem_if_pkg::*;
#(
    parameter int ADDR_WIDTH   = MEM_ADDR_WIDTH,
    parameter int LINE_WIDTH   = MEM_LINE_WIDTH,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_valid,
    output logic [LINE_WIDTH-1:0] i_rd,
    output logic                  i_ready,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wr,
    input  logic                  d_rw,
    input  logic                  d_valid,
    output logic [LINE_WIDTH-1:0] d_rd,
    output logic                  d_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wr,
    output logic                  mem_rw,
    output logic                  mem_valid,
    input  logic [LINE_WIDTH-1:0] mem_rd,
    input  logic                  mem_ready,
    output logic                  owner,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int WDOG_W = bitsFor(TIMEOUT - 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT - 1);

    arb_state_e            state_q;
    logic [ADDR_WIDTH-1:0] memAddr_q;
    logic [LINE_WIDTH-1:0] memWr_q;
    logic                  memRw_q;
    logic                  memValid_q;
    logic                  owner_q;
    logic                  busy_q;
    logic                  timeoutErr_q;
    logic [WDOG_W-1:0]     wdog_q;
    logic [WDOG_W-1:0]     wdog_d;
    logic                  grantEn;
    logic                  grantD;
    logic                  completing;

    // A grant is only taken from IDLE; requests seen while BUSY wait.
    assign grantEn = (state_q == ST_IDLE) && (i_valid || d_valid);

    arb_grant_logic #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .iValid_i  (i_valid),
        .dValid_i  (d_valid),
        .grantEn_i (grantEn),
        .grantD_o  (grantD)
    );

    // Watchdog next value: count BUSY cycles that end without mem_ready,
    // holding at TIMEOUT-1 instead of wrapping back to zero.
    always_comb begin
        wdog_d = wdog_q;
        if ((state_q == ST_BUSY) && !mem_ready && (wdog_q != WDOG_MAX)) begin
            wdog_d = wdog_q + WDOG_W'(1);
        end
    end

    // Main FSM with its registered command latch and status outputs.
    // timeout_err is set on the edge where the watchdog reaches TIMEOUT-1 so
    // the flag is visible in the same cycle the count shows that value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            memAddr_q    <= '0;
            memWr_q      <= '0;
            memRw_q      <= 1'b0;
            memValid_q   <= 1'b0;
            owner_q      <= OWNER_I;
            busy_q       <= 1'b0;
            timeoutErr_q <= 1'b0;
            wdog_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grantEn) begin
                        state_q    <= ST_BUSY;
                        memValid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        wdog_q     <= '0;
                        if (grantD) begin
                            owner_q   <= OWNER_D;
                            memAddr_q <= d_addr;
                            memWr_q   <= d_wr;
                            memRw_q   <= d_rw;
                        end else begin
                            owner_q   <= OWNER_I;
                            memAddr_q <= i_addr;
                            memWr_q   <= '0;
                            memRw_q   <= 1'b0;
                        end
                    end
                end
                ST_BUSY: begin
                    wdog_q <= wdog_d;
                    if (wdog_d == WDOG_MAX) begin
                        timeoutErr_q <= 1'b1;
                    end
                    if (mem_ready) begin
                        state_q    <= ST_IDLE;
                        memValid_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Completion is passed straight through in the mem_ready cycle, only to
    // the owner. Read data goes out only for reads; a reset in progress
    // suppresses the strobe so an abandoned transaction is never reported.
    always_comb begin
        completing = rst_n && (state_q == ST_BUSY) && mem_ready;
        i_ready    = completing && (owner_q == OWNER_I);
        d_ready    = completing && (owner_q == OWNER_D);
        i_rd       = i_ready ? mem_rd : '0;
        d_rd       = (d_ready && !memRw_q) ? mem_rd : '0;
    end

    assign mem_addr    = memAddr_q;
    assign mem_wr      = memWr_q;
    assign mem_rw      = memRw_q;
    assign mem_valid   = memValid_q;
    assign owner       = owner_q;
    assign busy        = busy_q;
    assign timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. A transaction-level model keeps
// the count of consecutive D wins over a waiting I-cache, the sticky timeout
// flag and the expected command/completion of each transaction.
module tb_mem_port_arbiter;

    localparam int AW    = 28;
    localparam int LW    = 256;
    localparam int LIMIT = 4;
    localparam int TOUT  = 1024;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] i_addr;
    logic          i_valid;
    logic [LW-1:0] i_rd;
    logic          i_ready;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_wr;
    logic          d_rw;
    logic          d_valid;
    logic [LW-1:0] d_rd;
    logic          d_ready;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wr;
    logic          mem_rw;
    logic          mem_valid;
    logic [LW-1:0] mem_rd;
    logic          mem_ready;
    logic          owner;
    logic          busy;
    logic          timeout_err;

    int errors;
    int checks;
    int modelStreak;
    bit modelTimeout;

    mem_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .LINE_WIDTH   (LW),
        .STARVE_LIMIT (LIMIT),
        .TIMEOUT      (TOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_addr      (i_addr),
        .i_valid     (i_valid),
        .i_rd        (i_rd),
        .i_ready     (i_ready),
        .d_addr      (d_addr),
        .d_wr        (d_wr),
        .d_rw        (d_rw),
        .d_valid     (d_valid),
        .d_rd        (d_rd),
        .d_ready     (d_ready),
        .mem_addr    (mem_addr),
        .mem_wr      (mem_wr),
        .mem_rw      (mem_rw),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_ready   (mem_ready),
        .owner       (owner),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LW-1:0] randLine();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [LW-1:0] observed,
                               input logic [LW-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mem_addr"}, LW'(mem_addr), '0);
        checkOutput({tag, "_mem_wr"}, mem_wr, '0);
        checkOutput({tag, "_flags"},
                    LW'({mem_rw, mem_valid, i_ready, d_ready, owner, busy, timeout_err}), '0);
        checkOutput({tag, "_i_rd"}, i_rd, '0);
        checkOutput({tag, "_d_rd"}, d_rd, '0);
    endtask

    task automatic newIRequest();
        i_valid = 1'b1;
        i_addr  = AW'($urandom);
    endtask

    task automatic newDRequest();
        d_valid = 1'b1;
        d_addr  = AW'($urandom);
        d_wr    = randLine();
        d_rw    = 1'($urandom_range(0, 1));
    endtask

    // Runs one transaction starting in an IDLE cycle with requests already
    // driven. latency = BUSY cycles before mem_ready. keepD re-raises the
    // D request right after a D completion; dropEarly withdraws the owner's
    // request (and scrambles its inputs) in the first BUSY cycle.
    task automatic applyStimulus(input int latency, input bit keepD, input bit dropEarly);
        bit            expD;
        logic [AW-1:0] expAddr;
        logic [LW-1:0] expWr;
        logic          expRw;
        logic [LW-1:0] rdData;
        int            busyCycles;

        expD    = d_valid && !(i_valid && modelStreak >= LIMIT);
        expAddr = expD ? d_addr : i_addr;
        expWr   = expD ? d_wr : '0;
        expRw   = expD ? d_rw : 1'b0;
        if (expD && i_valid) modelStreak = (modelStreak < LIMIT) ? modelStreak + 1 : LIMIT;
        else modelStreak = 0;

        @(posedge clk); #1;
        busyCycles = 1;
        checkOutput("busy", LW'(busy), LW'(1));
        checkOutput("mem_valid", LW'(mem_valid), LW'(1));
        checkOutput("owner", LW'(owner), LW'(expD));
        checkOutput("mem_addr", LW'(mem_addr), LW'(expAddr));
        checkOutput("mem_rw", LW'(mem_rw), LW'(expRw));
        checkOutput("mem_wr", mem_wr, expWr);
        checkOutput("timeout_err", LW'(timeout_err), LW'(modelTimeout));

        if (dropEarly) begin
            if (expD) begin
                d_valid = 1'b0;
                d_addr  = AW'($urandom);
                d_wr    = randLine();
                d_rw    = ~d_rw;
            end else begin
                i_valid = 1'b0;
                i_addr  = AW'($urandom);
            end
        end

        for (int k = 0; k < latency; k++) begin
            checkOutput("ready_wait", LW'({i_ready, d_ready}), '0);
            @(posedge clk); #1;
            busyCycles++;
            if (busyCycles >= TOUT) modelTimeout = 1'b1;
            checkOutput("timeout_err", LW'(timeout_err), LW'(modelTimeout));
            checkOutput("mem_addr_hold", LW'(mem_addr), LW'(expAddr));
        end

        rdData    = randLine();
        mem_rd    = rdData;
        mem_ready = 1'b1;
        #1;
        checkOutput("i_ready", LW'(i_ready), LW'(!expD));
        checkOutput("d_ready", LW'(d_ready), LW'(expD));
        checkOutput("i_rd", i_rd, expD ? '0 : rdData);
        checkOutput("d_rd", d_rd, (expD && !expRw) ? rdData : '0);

        @(posedge clk); #1;
        mem_ready = 1'b0;
        mem_rd    = randLine();
        checkOutput("idle_gap", LW'({busy, mem_valid, i_ready, d_ready}), '0);

        if (expD) begin
            if (keepD) newDRequest();
            else d_valid = 1'b0;
        end else begin
            i_valid = 1'b0;
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        modelStreak  = 0;
        modelTimeout = 1'b0;
        rst_n     = 1'b0;
        i_addr    = '0;
        i_valid   = 1'b0;
        d_addr    = '0;
        d_wr      = '0;
        d_rw      = 1'b0;
        d_valid   = 1'b0;
        mem_rd    = '0;
        mem_ready = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Lone I fill with three wait cycles.
        i_valid = 1'b1;
        i_addr  = 28'h0001230;
        applyStimulus(3, 1'b0, 1'b0);

        // Both at once: D write-back wins, then I after the idle gap.
        i_valid = 1'b1;
        i_addr  = 28'h0007770;
        d_valid = 1'b1;
        d_rw    = 1'b1;
        d_addr  = 28'h0004560;
        d_wr    = {LW/8{8'hAA}};
        applyStimulus(1, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b0);

        // D held continuously against a waiting I: D,D,D,D,I,D.
        newIRequest();
        newDRequest();
        for (int n = 0; n < 6; n++) applyStimulus(0, n < 5, 1'b0);

        // Fastest completion, then a stray mem_ready while idle.
        d_valid = 1'b1;
        d_rw    = 1'b0;
        d_addr  = 28'h00ABCD0;
        d_wr    = randLine();
        applyStimulus(0, 1'b0, 1'b0);
        mem_ready = 1'b1;
        mem_rd    = randLine();
        #1;
        checkOutput("idle_mem_ready", LW'({i_ready, d_ready}), '0);
        @(posedge clk); #1;
        checkOutput("idle_stays", LW'({busy, mem_valid}), '0);
        mem_ready = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 30; n++) begin
            if (!i_valid && ($urandom_range(0, 1) == 1)) newIRequest();
            if (!d_valid && ($urandom_range(0, 1) == 1)) newDRequest();
            if (!i_valid && !d_valid) newDRequest();
            applyStimulus(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
        end
        i_valid = 1'b0;
        d_valid = 1'b0;
        @(posedge clk); #1;

        // Watchdog: withhold mem_ready past the limit, then complete late.
        d_valid = 1'b1;
        d_rw    = 1'b0;
        d_addr  = 28'h0F00000;
        d_wr    = randLine();
        applyStimulus(TOUT + 20, 1'b0, 1'b0);
        checkOutput("timeout_sticky", LW'(timeout_err), LW'(1));
        newIRequest();
        applyStimulus(0, 1'b0, 1'b0);

        // Reset in the middle of a transaction.
        i_valid = 1'b1;
        i_addr  = 28'h0333330;
        @(posedge clk); #1;
        checkOutput("pre_reset_busy", LW'(busy), LW'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("reset_no_strobe", LW'({i_ready, d_ready}), '0);
        @(posedge clk); #1;
        checkAllZero("mid_reset");
        rst_n        = 1'b1;
        modelStreak  = 0;
        modelTimeout = 1'b0;
        applyStimulus(1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
